// File: rtl/output_uart_bridge_pkg.sv
// output_uart_pkg: shared definitions for the output UART bridge.
//   - uart_state_e : transmitter FSM states (PARITY exists in every build)
//   - DATA_BITS    : payload bits per frame
//   - FRAME_BITS_* : bit periods per frame without / with parity
//   - FRAME_BITS   : bit periods per frame for this build
// Optional feature macro: OUTPUT_UART_PARITY_EN (adds an even-parity bit).
package output_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  localparam int unsigned DATA_BITS      = 8;
  localparam int unsigned FRAME_BITS_8N1 = 10;
  localparam int unsigned FRAME_BITS_8E1 = 11;

`ifdef OUTPUT_UART_PARITY_EN
  localparam int unsigned FRAME_BITS = FRAME_BITS_8E1;
`else
  localparam int unsigned FRAME_BITS = FRAME_BITS_8N1;
`endif

endpackage

// File: rtl/output_uart_bridge_if.sv
// output_uart_bridge_if: CPU byte-output side plus UART/status outputs.
//   data_in     : byte from the CPU
//   data_in_new : one-cycle strobe, one byte per high cycle
//   tx          : UART serial line (idles high)
//   busy        : FIFO non-empty or frame in progress
//   overflow    : sticky dropped-byte flag
//   fifo_level  : FIFO occupancy
// Modports: master = CPU/bench side, slave = bridge side.
interface output_uart_bridge_if
  import output_uart_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16
) ();

  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_BITS-1:0] data_in;
  logic                 data_in_new;
  logic                 tx;
  logic                 busy;
  logic                 overflow;
  logic [LVL_W-1:0]     fifo_level;

  modport master (
    output data_in, data_in_new,
    input  tx, busy, overflow, fifo_level
  );

  modport slave (
    input  data_in, data_in_new,
    output tx, busy, overflow, fifo_level
  );

endinterface

// File: rtl/output_uart_bridge_fifo.sv
// byte_fifo: synchronous byte FIFO, power-of-two depth.
//   clk, rst : clock, asynchronous active-high reset
//   push/din : write request and data (ignored when full unless popping)
//   pop/dout : read request; dout shows the head entry combinationally
//   level    : occupancy; full/empty flags derived from it
module byte_fifo
  import output_uart_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [DATA_BITS-1:0]   din,
  output logic [DATA_BITS-1:0]   dout,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [DATA_BITS-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]     level_q, level_d;
  logic                 wr_en, rd_en;

  assign full  = (level_q == LVL_W'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;
  assign dout  = mem_q[rd_ptr_q];

  // A write into a full FIFO is allowed when the head leaves on the same edge.
  assign wr_en = push & (~full | pop);
  assign rd_en = pop & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr_en, rd_en})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/output_uart_bridge.sv
// output_uart_bridge: buffers CPU output bytes and sends them as UART frames.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : output_uart_bridge_if.slave (data_in, data_in_new, tx, busy,
//              overflow, fifo_level)
// Parameters: CLKS_PER_BIT (>= 2), FIFO_DEPTH (power of two, >= 2).
// Optional feature macro: OUTPUT_UART_PARITY_EN adds an even-parity bit
// between the data bits and the stop bit.
module output_uart_bridge
  import output_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  output_uart_bridge_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

  uart_state_e          state_q, state_d;
  logic [CNT_W-1:0]     clk_cnt_q, clk_cnt_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 tx_q, tx_d;
  logic                 overflow_q, overflow_d;
`ifdef OUTPUT_UART_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  logic [DATA_BITS-1:0] fifo_dout;
  logic [LVL_W-1:0]     fifo_level;
  logic                 fifo_full, fifo_empty;
  logic                 push, pop;
  logic                 bit_end;

  byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (bus.data_in),
    .dout  (fifo_dout),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign push       = bus.data_in_new & (~fifo_full | pop);
  assign overflow_d = overflow_q | (bus.data_in_new & ~push);
  assign bit_end    = (clk_cnt_q == CNT_W'(CLKS_PER_BIT - 1));

  assign bus.tx         = tx_q;
  assign bus.overflow   = overflow_q;
  assign bus.fifo_level = fifo_level;
  assign bus.busy       = (state_q != IDLE) | (fifo_level != '0);

  // tx_d is derived from the current state and registered, so the line
  // trails the FSM by one cycle; every state still lasts CLKS_PER_BIT cycles.
  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    tx_d      = 1'b1;
    pop       = 1'b0;
`ifdef OUTPUT_UART_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          pop       = 1'b1;
          shift_d   = fifo_dout;
          bit_cnt_d = '0;
          clk_cnt_d = '0;
`ifdef OUTPUT_UART_PARITY_EN
          parity_d  = ^fifo_dout;
`endif
          state_d   = START;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (bit_end) begin
          clk_cnt_d = '0;
          state_d   = DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      DATA: begin
        tx_d = shift_q[0];
        if (bit_end) begin
          clk_cnt_d = '0;
          shift_d   = shift_q >> 1;
          if (bit_cnt_q == 3'(DATA_BITS - 1)) begin
            bit_cnt_d = '0;
`ifdef OUTPUT_UART_PARITY_EN
            state_d   = PARITY;
`else
            state_d   = STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
`ifdef OUTPUT_UART_PARITY_EN
      PARITY: begin
        tx_d = parity_q;
        if (bit_end) begin
          clk_cnt_d = '0;
          state_d   = STOP;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
`endif
      STOP: begin
        tx_d = 1'b1;
        if (bit_end) begin
          clk_cnt_d = '0;
          // Chain straight into the next frame when a byte is waiting.
          if (!fifo_empty) begin
            pop       = 1'b1;
            shift_d   = fifo_dout;
            bit_cnt_d = '0;
`ifdef OUTPUT_UART_PARITY_EN
            parity_d  = ^fifo_dout;
`endif
            state_d   = START;
          end else begin
            state_d   = IDLE;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      clk_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      overflow_q <= 1'b0;
`ifdef OUTPUT_UART_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      clk_cnt_q  <= clk_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      overflow_q <= overflow_d;
`ifdef OUTPUT_UART_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

endmodule
